// File: rtl/uart_baudgen_frac.sv
// uart_baudgen_frac -- fractional-N oversampling tick generator for a UART.
// Emits a 1-cycle oversample tick (os_tick) at an average spacing of
// div_int + div_frac/2^FRAC_W clocks, and a bit-rate tick (baud_tick) on the
// os_tick that closes each bit. The divisor is offered through a one-entry
// valid/ready slot and switched in only at a bit boundary, on restart, or
// while the generator is idle, so no tick is ever stretched or chopped.
// Optional feature macro: UART_BAUDGEN_MIDBIT_EN adds the mid_tick output
// (RX sample-point pulse). With the macro undefined the port is absent.

module uart_baudgen_frac #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 1_000_000,
   parameter int OVERSAMPLE = 16,
   parameter int INT_W      = 16,
   parameter int FRAC_W     = 4,
   localparam int IDX_W     = $clog2(OVERSAMPLE)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              restart,
   input  logic              cfg_valid,
   input  logic [INT_W-1:0]  cfg_int,
   input  logic [FRAC_W-1:0] cfg_frac,
   output logic              cfg_ready,
   output logic              os_tick,
   output logic              baud_tick,
   output logic [IDX_W-1:0]  os_idx
`ifdef UART_BAUDGEN_MIDBIT_EN
   ,
   output logic              mid_tick
`endif
);

   // Reset divisor: round(CLK_HZ * 2^FRAC_W / (BAUD * OVERSAMPLE)) in 64-bit
   // arithmetic, since the scaled clock rate overflows 32 bits.
   localparam longint D_NUM     = longint'(CLK_HZ) * (longint'(1) << FRAC_W);
   localparam longint D_DEN     = longint'(BAUD) * longint'(OVERSAMPLE);
   localparam longint D_RST     = (D_NUM + D_NUM + D_DEN) / (D_DEN + D_DEN);
   localparam longint D_RST_INT = D_RST >> FRAC_W;

   localparam logic [INT_W-1:0]  INT_MIN  = INT_W'(2);
   localparam logic [INT_W-1:0]  INT_RST  = (D_RST_INT < 64'sd2) ? INT_MIN : INT_W'(D_RST_INT);
   localparam logic [FRAC_W-1:0] FRAC_RST = FRAC_W'(D_RST);

   localparam int                LEN_W    = INT_W + 1;
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0]  IDX_MID  = IDX_W'(OVERSAMPLE / 2);

   // Active divisor and the one-entry pending slot.
   logic [INT_W-1:0]  div_int_q;
   logic [FRAC_W-1:0] div_frac_q;
   logic [INT_W-1:0]  pend_int_q;
   logic [FRAC_W-1:0] pend_frac_q;
   logic              pend_full_q;

   // Period counter, fractional phase accumulator and oversample phase.
   logic [INT_W-1:0]  cnt_q;
   logic [FRAC_W-1:0] acc_q;
   logic [IDX_W-1:0]  os_idx_q;
   logic              os_tick_q;
   logic              baud_tick_q;

   logic [FRAC_W:0]   acc_sum;
   logic              carry;
   logic [INT_W:0]    len_m1;
   logic              term;
   logic              bit_end;
   logic              apply;
   logic              accept;
   logic [INT_W-1:0]  cfg_int_clamped;

   // The carry out of the fractional accumulator stretches this period by
   // one clock; across 2^FRAC_W periods that adds exactly div_frac clocks.
   assign acc_sum = {1'b0, acc_q} + {1'b0, div_frac_q};
   assign carry   = acc_sum[FRAC_W];
   assign len_m1  = {1'b0, div_int_q} + {{INT_W{1'b0}}, carry} - LEN_W'(1);

   // restart overrides en, so a terminal count is only honoured when running.
   assign term    = en && !restart && ({1'b0, cnt_q} == len_m1);
   assign bit_end = term && (os_idx_q == IDX_LAST);

   // The slot is only drained when it is full and only filled when it is
   // empty, so a capture and an apply can never collide in one cycle.
   assign apply   = pend_full_q && (bit_end || restart || !en);
   assign accept  = cfg_valid && !pend_full_q;

   // A divisor below 2 would leave no room for the 1-cycle tick to drop.
   assign cfg_int_clamped = (cfg_int < INT_MIN) ? INT_MIN : cfg_int;

   // Divisor slot: capture an offered divisor, hand it over at a safe point.
   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_int_q   <= INT_RST;
         div_frac_q  <= FRAC_RST;
         // NOTE: the slot payload is reset too; it is tiny and a known value
         // keeps a stale divisor from ever leaking out after reset.
         pend_int_q  <= INT_RST;
         pend_frac_q <= FRAC_RST;
         pend_full_q <= 1'b0;
      end else if (apply) begin
         div_int_q   <= pend_int_q;
         div_frac_q  <= pend_frac_q;
         pend_full_q <= 1'b0;
      end else if (accept) begin
         pend_int_q  <= cfg_int_clamped;
         pend_frac_q <= cfg_frac;
         pend_full_q <= 1'b1;
      end
   end

   // Period counter, accumulator and oversample phase; hold while en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         os_idx_q <= '0;
      end else if (restart) begin
         // Re-phase to mid-bit so the first baud_tick lands half a bit later.
         cnt_q    <= '0;
         acc_q    <= '0;
         os_idx_q <= IDX_MID;
      end else if (en) begin
         if (term) begin
            cnt_q    <= '0;
            acc_q    <= acc_sum[FRAC_W-1:0];
            os_idx_q <= (os_idx_q == IDX_LAST) ? '0 : os_idx_q + IDX_W'(1);
         end else begin
            cnt_q    <= cnt_q + INT_W'(1);
         end
      end
   end

   // Registered tick pulses, one cycle after the terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         os_tick_q   <= 1'b0;
         baud_tick_q <= 1'b0;
      end else begin
         os_tick_q   <= term;
         baud_tick_q <= bit_end;
      end
   end

`ifdef UART_BAUDGEN_MIDBIT_EN
   logic mid_tick_q;

   // Sample-point pulse: the os_tick on which os_idx steps to mid-bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mid_tick_q <= 1'b0;
      end else begin
         mid_tick_q <= term && (os_idx_q == IDX_MID - IDX_W'(1));
      end
   end

   assign mid_tick = mid_tick_q;
`endif

   assign cfg_ready = !pend_full_q;
   assign os_tick   = os_tick_q;
   assign baud_tick = baud_tick_q;
   assign os_idx    = os_idx_q;

endmodule
